// File: rtl/ureg_pkg.sv
// ureg_pkg: shared definitions for the universal register ureg_w.
//   UREG_MODE_W      width of the mode select
//   UREG_HOLD..DEC   3-bit operation codes; all eight codes are defined
package ureg_pkg;

    localparam int UREG_MODE_W = 3;

    localparam logic [UREG_MODE_W-1:0] UREG_HOLD = 3'd0;
    localparam logic [UREG_MODE_W-1:0] UREG_LOAD = 3'd1;
    localparam logic [UREG_MODE_W-1:0] UREG_SHL  = 3'd2;
    localparam logic [UREG_MODE_W-1:0] UREG_SHR  = 3'd3;
    localparam logic [UREG_MODE_W-1:0] UREG_ROL  = 3'd4;
    localparam logic [UREG_MODE_W-1:0] UREG_ROR  = 3'd5;
    localparam logic [UREG_MODE_W-1:0] UREG_INC  = 3'd6;
    localparam logic [UREG_MODE_W-1:0] UREG_DEC  = 3'd7;

endpackage

// File: rtl/ureg_next.sv
// ureg_next: combinational next-state logic for ureg_w.
//   Inputs : q, co (current state), mode, d, sl_in, sr_in
//   Outputs: next_q, next_co (state to register when enabled)
// No handshakes: every mode code is a legal, single-cycle operation.
module ureg_next
    import ureg_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]           q,
    input  logic                   co,
    input  logic [UREG_MODE_W-1:0] mode,
    input  logic [W-1:0]           d,
    input  logic                   sl_in,
    input  logic                   sr_in,
    output logic [W-1:0]           next_q,
    output logic                   next_co
);

    // INC is evaluated W+1 bits wide so the carry drops straight out.
    logic [W:0] inc_sum;

    always_comb begin
        inc_sum = {1'b0, q} + {{W{1'b0}}, 1'b1};
        next_q  = q;
        next_co = co;
        case (mode)
            UREG_LOAD: begin
                next_q  = d;
                next_co = 1'b0;
            end
            UREG_SHL: begin
                next_q  = {q[W-2:0], sl_in};
                next_co = q[W-1];
            end
            UREG_SHR: begin
                next_q  = {sr_in, q[W-1:1]};
                next_co = q[0];
            end
            UREG_ROL: begin
                next_q  = {q[W-2:0], q[W-1]};
                next_co = q[W-1];
            end
            UREG_ROR: begin
                next_q  = {q[0], q[W-1:1]};
                next_co = q[0];
            end
            UREG_INC: begin
                next_q  = inc_sum[W-1:0];
                next_co = inc_sum[W];
            end
            UREG_DEC: begin
                // Borrow out only when wrapping from zero to all-ones.
                next_q  = q - {{(W-1){1'b0}}, 1'b1};
                next_co = (q == '0);
            end
            default: begin
                // HOLD: state unchanged, co keeps describing the last real op.
                next_q  = q;
                next_co = co;
            end
        endcase
    end

endmodule

// File: rtl/ureg_w.sv
// ureg_w: parametrised universal register with clock enable and mode select.
//   clk    rising-edge clock
//   r      synchronous active-high reset (priority over en and mode)
//   en     clock enable; 0 holds q and co
//   mode   operation select (see ureg_pkg)
//   d      parallel load data
//   sl_in  serial bit entering LSB on SHL
//   sr_in  serial bit entering MSB on SHR
//   q      register contents
//   co     registered carry / borrow / shifted-out bit
//   zero   combinational (q == 0)
module ureg_w
    import ureg_pkg::*;
#(
    parameter int          W         = 8,
    parameter logic [63:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   r,
    input  logic                   en,
    input  logic [UREG_MODE_W-1:0] mode,
    input  logic [W-1:0]           d,
    input  logic                   sl_in,
    input  logic                   sr_in,
    output logic [W-1:0]           q,
    output logic                   co,
    output logic                   zero
);

    logic [W-1:0] q_q, q_d;
    logic         co_q, co_d;
    logic [W-1:0] next_q;
    logic         next_co;

    ureg_next #(.W(W)) u_next (
        .q       (q_q),
        .co      (co_q),
        .mode    (mode),
        .d       (d),
        .sl_in   (sl_in),
        .sr_in   (sr_in),
        .next_q  (next_q),
        .next_co (next_co)
    );

    // Priority: reset, then enable, then the mode-selected next state.
    always_comb begin
        q_d  = q_q;
        co_d = co_q;
        if (r) begin
            q_d  = RESET_VAL[W-1:0];
            co_d = 1'b0;
        end else if (en) begin
            q_d  = next_q;
            co_d = next_co;
        end
    end

    always_ff @(posedge clk) begin
        q_q  <= q_d;
        co_q <= co_d;
    end

    assign q    = q_q;
    assign co   = co_q;
    assign zero = (q_q == '0);

endmodule

// File: tb/tb_ureg_w.sv
// tb_ureg_w: directed self-checking bench for ureg_w at W=8, W=4 (RESET_VAL=9)
// and W=16. All three instances share one stimulus bus; each task checks the
// instance it targets against hand-computed values.
module tb_ureg_w;
    import ureg_pkg::*;

    logic        clk;
    logic        r;
    logic        en;
    logic [2:0]  mode;
    logic [15:0] d;
    logic        sl_in;
    logic        sr_in;

    logic [7:0]  q8;
    logic        co8, zero8;
    logic [3:0]  q4;
    logic        co4, zero4;
    logic [15:0] q16;
    logic        co16, zero16;

    int checks;
    int errors;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    ureg_w #(.W(8), .RESET_VAL(64'h0)) dut8 (
        .clk(clk), .r(r), .en(en), .mode(mode), .d(d[7:0]),
        .sl_in(sl_in), .sr_in(sr_in), .q(q8), .co(co8), .zero(zero8)
    );

    ureg_w #(.W(4), .RESET_VAL(64'h9)) dut4 (
        .clk(clk), .r(r), .en(en), .mode(mode), .d(d[3:0]),
        .sl_in(sl_in), .sr_in(sr_in), .q(q4), .co(co4), .zero(zero4)
    );

    ureg_w #(.W(16), .RESET_VAL(64'h0)) dut16 (
        .clk(clk), .r(r), .en(en), .mode(mode), .d(d),
        .sl_in(sl_in), .sr_in(sr_in), .q(q16), .co(co16), .zero(zero16)
    );

    // ---------------- driver ----------------
    // Drive one cycle of inputs, take the rising edge, sample 1 time unit later.
    task automatic apply(input logic rr, input logic ee, input logic [2:0] mm,
                         input logic [15:0] dd, input logic sl, input logic sr);
        r     = rr;
        en    = ee;
        mode  = mm;
        d     = dd;
        sl_in = sl;
        sr_in = sr;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset_load();
        apply(1'b1, 1'b0, UREG_HOLD, 16'h0000, 1'b0, 1'b0);
        checks++; if (q8 !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp %h", q8, 8'h00); end
        checks++; if (co8 !== 1'b0) begin errors++; $display("FAIL reset_co got %b exp %b", co8, 1'b0); end
        checks++; if (zero8 !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp %b", zero8, 1'b1); end
        apply(1'b0, 1'b1, UREG_LOAD, 16'h00A5, 1'b0, 1'b0);
        checks++; if (q8 !== 8'hA5) begin errors++; $display("FAIL load_q got %h exp %h", q8, 8'hA5); end
        checks++; if (zero8 !== 1'b0) begin errors++; $display("FAIL load_zero got %b exp %b", zero8, 1'b0); end
        // en=0 holds regardless of mode
        apply(1'b0, 1'b0, UREG_LOAD, 16'h003C, 1'b0, 1'b0);
        checks++; if (q8 !== 8'hA5) begin errors++; $display("FAIL en_low_hold_q got %h exp %h", q8, 8'hA5); end
        apply(1'b1, 1'b1, UREG_LOAD, 16'h005A, 1'b0, 1'b0);
        checks++; if (q8 !== 8'h00) begin errors++; $display("FAIL reset_priority_q got %h exp %h", q8, 8'h00); end
    endtask

    task automatic test_shift();
        apply(1'b0, 1'b1, UREG_LOAD, 16'h0081, 1'b0, 1'b0);
        apply(1'b0, 1'b1, UREG_SHL, 16'h0000, 1'b1, 1'b0);
        checks++; if (q8 !== 8'h03) begin errors++; $display("FAIL shl_q got %h exp %h", q8, 8'h03); end
        checks++; if (co8 !== 1'b1) begin errors++; $display("FAIL shl_co got %b exp %b", co8, 1'b1); end
        apply(1'b0, 1'b1, UREG_SHR, 16'h0000, 1'b0, 1'b0);
        checks++; if (q8 !== 8'h01) begin errors++; $display("FAIL shr1_q got %h exp %h", q8, 8'h01); end
        checks++; if (co8 !== 1'b1) begin errors++; $display("FAIL shr1_co got %b exp %b", co8, 1'b1); end
        apply(1'b0, 1'b1, UREG_SHR, 16'h0000, 1'b0, 1'b0);
        checks++; if (q8 !== 8'h00) begin errors++; $display("FAIL shr2_q got %h exp %h", q8, 8'h00); end
        checks++; if (co8 !== 1'b1) begin errors++; $display("FAIL shr2_co got %b exp %b", co8, 1'b1); end
        checks++; if (zero8 !== 1'b1) begin errors++; $display("FAIL shr2_zero got %b exp %b", zero8, 1'b1); end
        // sr_in enters at the MSB; shifted-out bit is 0
        apply(1'b0, 1'b1, UREG_SHR, 16'h0000, 1'b0, 1'b1);
        checks++; if (q8 !== 8'h80) begin errors++; $display("FAIL shr_in_q got %h exp %h", q8, 8'h80); end
        checks++; if (co8 !== 1'b0) begin errors++; $display("FAIL shr_in_co got %b exp %b", co8, 1'b0); end
    endtask

    task automatic test_rotate();
        apply(1'b0, 1'b1, UREG_LOAD, 16'h0080, 1'b0, 1'b0);
        apply(1'b0, 1'b1, UREG_ROL, 16'h0000, 1'b0, 1'b0);
        checks++; if (q8 !== 8'h01) begin errors++; $display("FAIL rol_q got %h exp %h", q8, 8'h01); end
        checks++; if (co8 !== 1'b1) begin errors++; $display("FAIL rol_co got %b exp %b", co8, 1'b1); end
        apply(1'b0, 1'b1, UREG_ROR, 16'h0000, 1'b1, 1'b1);
        checks++; if (q8 !== 8'h80) begin errors++; $display("FAIL ror1_q got %h exp %h", q8, 8'h80); end
        checks++; if (co8 !== 1'b1) begin errors++; $display("FAIL ror1_co got %b exp %b", co8, 1'b1); end
        for (int i = 0; i < 7; i++) apply(1'b0, 1'b1, UREG_ROR, 16'h0000, 1'b1, 1'b1);
        checks++; if (q8 !== 8'h01) begin errors++; $display("FAIL ror8_q got %h exp %h", q8, 8'h01); end
        checks++; if (co8 !== 1'b0) begin errors++; $display("FAIL ror8_co got %b exp %b", co8, 1'b0); end
    endtask

    task automatic test_counter();
        apply(1'b0, 1'b1, UREG_LOAD, 16'h00FE, 1'b0, 1'b0);
        apply(1'b0, 1'b1, UREG_INC, 16'h0000, 1'b0, 1'b0);
        checks++; if (q8 !== 8'hFF) begin errors++; $display("FAIL inc1_q got %h exp %h", q8, 8'hFF); end
        checks++; if (co8 !== 1'b0) begin errors++; $display("FAIL inc1_co got %b exp %b", co8, 1'b0); end
        apply(1'b0, 1'b1, UREG_INC, 16'h0000, 1'b0, 1'b0);
        checks++; if (q8 !== 8'h00) begin errors++; $display("FAIL inc_wrap_q got %h exp %h", q8, 8'h00); end
        checks++; if (co8 !== 1'b1) begin errors++; $display("FAIL inc_wrap_co got %b exp %b", co8, 1'b1); end
        checks++; if (zero8 !== 1'b1) begin errors++; $display("FAIL inc_wrap_zero got %b exp %b", zero8, 1'b1); end
        // HOLD keeps co from the last real operation
        apply(1'b0, 1'b1, UREG_HOLD, 16'h00AA, 1'b0, 1'b0);
        checks++; if (co8 !== 1'b1) begin errors++; $display("FAIL hold_co got %b exp %b", co8, 1'b1); end
        apply(1'b0, 1'b1, UREG_DEC, 16'h0000, 1'b0, 1'b0);
        checks++; if (q8 !== 8'hFF) begin errors++; $display("FAIL dec_wrap_q got %h exp %h", q8, 8'hFF); end
        checks++; if (co8 !== 1'b1) begin errors++; $display("FAIL dec_wrap_co got %b exp %b", co8, 1'b1); end
        apply(1'b0, 1'b1, UREG_DEC, 16'h0000, 1'b0, 1'b0);
        checks++; if (q8 !== 8'hFE) begin errors++; $display("FAIL dec2_q got %h exp %h", q8, 8'hFE); end
        checks++; if (co8 !== 1'b0) begin errors++; $display("FAIL dec2_co got %b exp %b", co8, 1'b0); end
    endtask

    task automatic test_enable_reset();
        logic [7:0] exp_seq [4];
        logic       en_seq  [4];
        exp_seq = '{8'h01, 8'h02, 8'h02, 8'h03};
        en_seq  = '{1'b1, 1'b1, 1'b0, 1'b1};
        apply(1'b0, 1'b1, UREG_LOAD, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, en_seq[i], UREG_INC, 16'h0000, 1'b0, 1'b0);
            checks++; if (q8 !== exp_seq[i]) begin errors++; $display("FAIL en_seq[%0d] got %h exp %h", i, q8, exp_seq[i]); end
        end
        apply(1'b0, 1'b1, UREG_INC, 16'h0000, 1'b0, 1'b0);
        apply(1'b0, 1'b1, UREG_INC, 16'h0000, 1'b0, 1'b0);
        checks++; if (q8 !== 8'h05) begin errors++; $display("FAIL count5_q got %h exp %h", q8, 8'h05); end
        apply(1'b1, 1'b1, UREG_INC, 16'h0000, 1'b0, 1'b0);
        checks++; if (q8 !== 8'h00) begin errors++; $display("FAIL mid_reset_q got %h exp %h", q8, 8'h00); end
        apply(1'b0, 1'b1, UREG_INC, 16'h0000, 1'b0, 1'b0);
        checks++; if (q8 !== 8'h01) begin errors++; $display("FAIL after_reset_q got %h exp %h", q8, 8'h01); end
    endtask

    task automatic test_w4();
        apply(1'b1, 1'b0, UREG_HOLD, 16'h0000, 1'b0, 1'b0);
        checks++; if (q4 !== 4'h9) begin errors++; $display("FAIL w4_reset_q got %h exp %h", q4, 4'h9); end
        checks++; if (zero4 !== 1'b0) begin errors++; $display("FAIL w4_reset_zero got %b exp %b", zero4, 1'b0); end
        checks++; if (co4 !== 1'b0) begin errors++; $display("FAIL w4_reset_co got %b exp %b", co4, 1'b0); end
        apply(1'b0, 1'b1, UREG_LOAD, 16'h000F, 1'b0, 1'b0);
        apply(1'b0, 1'b1, UREG_INC, 16'h0000, 1'b0, 1'b0);
        checks++; if (q4 !== 4'h0) begin errors++; $display("FAIL w4_inc_q got %h exp %h", q4, 4'h0); end
        checks++; if (co4 !== 1'b1) begin errors++; $display("FAIL w4_inc_co got %b exp %b", co4, 1'b1); end
        checks++; if (zero4 !== 1'b1) begin errors++; $display("FAIL w4_inc_zero got %b exp %b", zero4, 1'b1); end
    endtask

    task automatic test_w16();
        apply(1'b1, 1'b0, UREG_HOLD, 16'h0000, 1'b0, 1'b0);
        checks++; if (q16 !== 16'h0000) begin errors++; $display("FAIL w16_reset_q got %h exp %h", q16, 16'h0000); end
        checks++; if (zero16 !== 1'b1) begin errors++; $display("FAIL w16_reset_zero got %b exp %b", zero16, 1'b1); end
        apply(1'b0, 1'b1, UREG_LOAD, 16'hA5C3, 1'b0, 1'b0);
        checks++; if (q16 !== 16'hA5C3) begin errors++; $display("FAIL w16_load_q got %h exp %h", q16, 16'hA5C3); end
        apply(1'b1, 1'b1, UREG_LOAD, 16'h1234, 1'b0, 1'b0);
        checks++; if (q16 !== 16'h0000) begin errors++; $display("FAIL w16_reset_prio_q got %h exp %h", q16, 16'h0000); end
        // shift
        apply(1'b0, 1'b1, UREG_LOAD, 16'h8001, 1'b0, 1'b0);
        apply(1'b0, 1'b1, UREG_SHL, 16'h0000, 1'b1, 1'b0);
        checks++; if (q16 !== 16'h0003 || co16 !== 1'b1) begin errors++; $display("FAIL w16_shl got %h/%b exp %h/%b", q16, co16, 16'h0003, 1'b1); end
        apply(1'b0, 1'b1, UREG_SHR, 16'h0000, 1'b0, 1'b0);
        checks++; if (q16 !== 16'h0001 || co16 !== 1'b1) begin errors++; $display("FAIL w16_shr1 got %h/%b exp %h/%b", q16, co16, 16'h0001, 1'b1); end
        apply(1'b0, 1'b1, UREG_SHR, 16'h0000, 1'b0, 1'b0);
        checks++; if (q16 !== 16'h0000 || co16 !== 1'b1 || zero16 !== 1'b1) begin errors++; $display("FAIL w16_shr2 got %h/%b/%b exp 0000/1/1", q16, co16, zero16); end
        // rotate
        apply(1'b0, 1'b1, UREG_LOAD, 16'h8000, 1'b0, 1'b0);
        apply(1'b0, 1'b1, UREG_ROL, 16'h0000, 1'b0, 1'b0);
        checks++; if (q16 !== 16'h0001 || co16 !== 1'b1) begin errors++; $display("FAIL w16_rol got %h/%b exp %h/%b", q16, co16, 16'h0001, 1'b1); end
        for (int i = 0; i < 16; i++) apply(1'b0, 1'b1, UREG_ROR, 16'h0000, 1'b0, 1'b0);
        checks++; if (q16 !== 16'h0001 || co16 !== 1'b0) begin errors++; $display("FAIL w16_ror16 got %h/%b exp %h/%b", q16, co16, 16'h0001, 1'b0); end
        // counter wrap
        apply(1'b0, 1'b1, UREG_LOAD, 16'hFFFE, 1'b0, 1'b0);
        apply(1'b0, 1'b1, UREG_INC, 16'h0000, 1'b0, 1'b0);
        checks++; if (q16 !== 16'hFFFF || co16 !== 1'b0) begin errors++; $display("FAIL w16_inc1 got %h/%b exp %h/%b", q16, co16, 16'hFFFF, 1'b0); end
        apply(1'b0, 1'b1, UREG_INC, 16'h0000, 1'b0, 1'b0);
        checks++; if (q16 !== 16'h0000 || co16 !== 1'b1 || zero16 !== 1'b1) begin errors++; $display("FAIL w16_inc_wrap got %h/%b/%b exp 0000/1/1", q16, co16, zero16); end
        apply(1'b0, 1'b1, UREG_DEC, 16'h0000, 1'b0, 1'b0);
        checks++; if (q16 !== 16'hFFFF || co16 !== 1'b1) begin errors++; $display("FAIL w16_dec_wrap got %h/%b exp %h/%b", q16, co16, 16'hFFFF, 1'b1); end
        apply(1'b0, 1'b1, UREG_DEC, 16'h0000, 1'b0, 1'b0);
        checks++; if (q16 !== 16'hFFFE || co16 !== 1'b0) begin errors++; $display("FAIL w16_dec2 got %h/%b exp %h/%b", q16, co16, 16'hFFFE, 1'b0); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks = 0;
        errors = 0;
        r      = 1'b1;
        en     = 1'b0;
        mode   = UREG_HOLD;
        d      = '0;
        sl_in  = 1'b0;
        sr_in  = 1'b0;

        test_reset_load();
        test_shift();
        test_rotate();
        test_counter();
        test_enable_reset();
        test_w4();
        test_w16();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ureg_w.md
# ureg_w

Parametrised universal register: the W-bit successor to the team's 4-bit reset/load register. It adds a clock enable, a parametrised reset value, and an eight-way mode select: hold, load, logical shift, rotate, increment and decrement. It also provides a registered carry/shift-out bit and a zero flag. It is the generic state element for datapath accumulators, serial converters and loop counters.

## Interface

Parameters:
- W, 8, data width; legal range 2..64.
- RESET_VAL, 0, value of q after reset; only the low W bits are used.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- r  input  1  reset; synchronous, active-high.
- en  input  1  clock enable; 0 holds all state.
- mode  input  3  operation select; encodings are given under Operation.
- d  input  W  parallel load data.
- sl_in  input  1  serial bit entering at the LSB on a left shift.
- sr_in  input  1  serial bit entering at the MSB on a right shift.
- q  output  W  register contents.
- co  output  1  registered carry, borrow or shifted-out bit.
- zero  output  1  combinational (q == 0).

## Operation

- Priority on each rising edge of clk: r, then en, then mode.
- r=1: q <= RESET_VAL, co <= 0. This applies regardless of en and mode.
- en=0 (with r=0): q and co are held.
- en=1 (with r=0), by mode:
  - 0 HOLD: q held, co held.
  - 1 LOAD: q <= d, co <= 0.
  - 2 SHL: q <= {q[W-2:0], sl_in}, co <= q[W-1].
  - 3 SHR: q <= {sr_in, q[W-1:1]}, co <= q[0].
  - 4 ROL: q <= {q[W-2:0], q[W-1]}, co <= q[W-1].
  - 5 ROR: q <= {q[0], q[W-1:1]}, co <= q[0].
  - 6 INC: {co, q} <= q + 1, computed W+1 bits wide. co=1 only on wrap from all-ones to 0.
  - 7 DEC: q <= q - 1 modulo 2^W, co <= (q == 0). co=1 only on wrap from 0 to all-ones.
- Arithmetic is unsigned modulo 2^W. There is no saturation.
- co always describes the most recent enabled non-HOLD operation. After a LOAD it is 0.
- zero is purely combinational from q and has no state of its own.

## Timing

- Latency: one cycle. The effect of inputs sampled at edge N is visible on q and co immediately after edge N.
- zero follows q in the same cycle, with no extra register stage.
- Reset values: q = RESET_VAL, co = 0, zero = (RESET_VAL == 0).
- Reset is synchronous only. Asserting r between edges changes nothing until the next rising edge.
- Reset mid-sequence, for example in the middle of a count or shift: the operation is abandoned at that edge. Operation resumes from RESET_VAL on the first edge with r=0 and en=1.
- en toggling: a cycle with en=0 inserts exactly one hold cycle and loses no data.
- Mode changes take effect on the next edge. No mode has any multi-cycle state.
- There are no handshakes. The block has no illegal inputs, because all 8 mode codes are defined.

## Structure

Shared package ureg_pkg holds:
- the 3-bit mode localparams UREG_HOLD, UREG_LOAD, UREG_SHL, UREG_SHR, UREG_ROL, UREG_ROR, UREG_INC and UREG_DEC;
- the constant UREG_MODE_W = 3.

One sub-module is natural: ureg_next, a combinational function of W, q, co, mode, d, sl_in and sr_in that produces next_q and next_co. The top level keeps only the register, the r/en priority logic and the zero compare. This lets the verification engineer check the next-state logic in isolation.

## Test plan

All scenarios use W=8 and RESET_VAL=8'h00 unless noted.

1. Reset and load:
   - Pulse r, then LOAD with d=8'hA5. Expect q=00, co=0, zero=1 after the reset edge, then q=A5, zero=0.
   - Assert r and LOAD in the same cycle. Expect q=00, confirming reset priority.
2. Shift:
   - From q=8'h81, SHL with sl_in=1. Expect q=03, co=1.
   - Then SHR with sr_in=0. Expect q=01, co=1.
   - Then SHR again. Expect q=00, co=1, zero=1.
3. Rotate:
   - From q=8'h80, ROL. Expect q=01, co=1.
   - Then 8 consecutive RORs. Expect q=01 after the 8th, with co=0 on that final step.
4. Counter wrap:
   - LOAD FE, then INC, INC. Expect FF with co=0, then 00 with co=1 and zero=1.
   - Then DEC. Expect FF, co=1.
   - Then DEC. Expect FE, co=0.
5. Enable and mid-operation reset:
   - INC counting from 00 with en low on cycle 3. Expect the sequence 01, 02, 02, 03.
   - Assert r at count 05. Expect 00 on that edge, then 01 on the next enabled INC.
6. Parameter sweep:
   - W=4, RESET_VAL=4'h9. After reset expect q=9, zero=0.
   - INC from F. Expect 0, co=1.
   - Repeat scenarios 1-4 with W=16 to check the width generalisation.
